// File: rtl/frog_move_scheduler.sv
// Turns raw USB keycodes into frame-aligned single-step moves for the selected frog.
// Optional build macro MOVE_STATS_EN: enables the issued_count move counter.
//
//   state     | meaning
//   S_IDLE    | waiting for a frame tick with a queued move and a frog selected
//   S_ISSUE   | move_valid/move_dir held for one frame period
//   S_HOLDOFF | cool-down frames after a move, no new issue
//   S_HALT    | frog dying or game over; queue flushed, pushes ignored
module frog_move_scheduler #(
  parameter int FIFO_DEPTH      = 4,
  parameter int REPEAT_FRAMES   = 8,
  parameter int COOLDOWN_FRAMES = 1
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic [15:0]                 keycode,
  input  logic                        frame_vs,
  input  logic                        dead_frog,
  input  logic                        win,
  input  logic                        lose,
  output logic [2:0]                  active_frog,
  output logic                        move_valid,
  output logic [1:0]                  move_dir,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        halted,
  output logic [15:0]                 issued_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
  localparam logic [3:0] CD_LOAD = 4'(COOLDOWN_FRAMES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLDOFF, S_HALT} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cd_cnt, cd_nxt;

  logic        vs_meta, vs_sync, vs_sync_d, tick;

  logic [7:0]  key, prev_key;
  logic        key_changed;
  logic        is_arrow, is_select;
  logic [1:0]  key_dir;
  logic [2:0]  sel_onehot;
  logic        arrow_press, sel_press, rep_hit;

  logic        halt_req, push_req, flush, pop;
  logic        fifo_full, do_push, drop;
  logic [1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  logic        unused_key_hi;
  assign unused_key_hi = ^keycode[15:8];

  // frame_vs is asynchronous; the tick is registered after the edge detect
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      vs_meta   <= 1'b0;
      vs_sync   <= 1'b0;
      vs_sync_d <= 1'b0;
      tick      <= 1'b0;
    end else begin
      vs_meta   <= frame_vs;
      vs_sync   <= vs_meta;
      vs_sync_d <= vs_sync;
      tick      <= vs_sync & ~vs_sync_d;
    end
  end

  assign key         = keycode[7:0];
  assign key_changed = (key != prev_key);

  always_comb begin
    is_arrow   = 1'b0;
    key_dir    = 2'd0;
    is_select  = 1'b0;
    sel_onehot = 3'b000;
    case (key)
      8'h52: begin is_arrow = 1'b1; key_dir = 2'd0; end
      8'h51: begin is_arrow = 1'b1; key_dir = 2'd1; end
      8'h50: begin is_arrow = 1'b1; key_dir = 2'd2; end
      8'h4F: begin is_arrow = 1'b1; key_dir = 2'd3; end
      8'h59: begin is_select = 1'b1; sel_onehot = 3'b001; end
      8'h5A: begin is_select = 1'b1; sel_onehot = 3'b010; end
      8'h5B: begin is_select = 1'b1; sel_onehot = 3'b100; end
      default: ;
    endcase
  end

  assign arrow_press = is_arrow & key_changed;
  assign sel_press   = is_select & key_changed;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      prev_key    <= 8'h00;
      active_frog <= 3'b000;
    end else begin
      prev_key <= key;
      if (sel_press)
        active_frog <= sel_onehot;
    end
  end

  generate
    if (REPEAT_FRAMES > 0) begin : g_repeat
      logic          held;
      logic [RW-1:0] repeat_cnt;

      assign held    = is_arrow & ~key_changed;
      assign rep_hit = held & tick & (repeat_cnt == RW'(REPEAT_FRAMES - 1));

      always_ff @(posedge Clk) begin
        if (!Reset_n)
          repeat_cnt <= '0;
        else if (!held)
          repeat_cnt <= '0;
        else if (tick)
          repeat_cnt <= rep_hit ? '0 : repeat_cnt + 1'b1;
      end
    end else begin : g_no_repeat
      assign rep_hit = 1'b0;
    end
  endgenerate

  assign halt_req  = dead_frog | win | lose;
  assign push_req  = (arrow_press | rep_hit) & (|active_frog) & (state != S_HALT);
  assign flush     = sel_press | halt_req;
  assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));
  // a pop in the same cycle frees the slot, so a full queue still accepts
  assign do_push   = push_req & ~flush & (~fifo_full | pop);
  assign drop      = push_req & ~flush & fifo_full & ~pop;

  always_ff @(posedge Clk) begin
    if (do_push)
      mem[wr_ptr] <= key_dir;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (drop)
        overflow <= 1'b1;
      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
      end else begin
        if (do_push)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        case ({do_push, pop})
          2'b10:   fifo_count <= fifo_count + 1'b1;
          2'b01:   fifo_count <= fifo_count - 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cd_nxt    = cd_cnt;
    pop       = 1'b0;
    if (halt_req) begin
      state_nxt = S_HALT;
      cd_nxt    = 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          // a selection in the same cycle flushes the head too, so nothing issues
          if (tick && (fifo_count != '0) && (|active_frog) && !sel_press) begin
            pop       = 1'b1;
            state_nxt = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (tick) begin
            if (COOLDOWN_FRAMES == 0) begin
              state_nxt = S_IDLE;
            end else begin
              state_nxt = S_HOLDOFF;
              cd_nxt    = CD_LOAD;
            end
          end
        end
        S_HOLDOFF: begin
          if (tick) begin
            cd_nxt = cd_cnt - 4'd1;
            if (cd_cnt <= 4'd1) begin
              state_nxt = S_IDLE;
              cd_nxt    = 4'd0;
            end
          end
        end
        S_HALT: begin
          if (tick)
            state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state    <= S_IDLE;
      cd_cnt   <= 4'd0;
      move_dir <= 2'd0;
    end else begin
      state  <= state_nxt;
      cd_cnt <= cd_nxt;
      if (pop)
        move_dir <= mem[rd_ptr];
    end
  end

  assign move_valid = (state == S_ISSUE);
  assign halted     = (state == S_HALT);

`ifdef MOVE_STATS_EN
  always_ff @(posedge Clk) begin
    if (!Reset_n)
      issued_count <= 16'd0;
    else if (pop)
      issued_count <= issued_count + 16'd1;
  end
`else
  assign issued_count = 16'd0;
`endif

endmodule

// File: tb/tb_frog_move_scheduler.sv
// Bench for frog_move_scheduler: queue-based reference model checked every cycle plus directed literal checks.
module tb_frog_move_scheduler;

  localparam int DEPTH = 4;
  localparam int REP   = 8;
  localparam int COOL  = 1;

  localparam int PH_IDLE   = 0;
  localparam int PH_MOVING = 1;
  localparam int PH_REST   = 2;
  localparam int PH_HALT   = 3;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [15:0] keycode = 16'h0052;
  logic        frame_vs = 1'b0;
  logic        dead_frog = 1'b0;
  logic        win = 1'b0;
  logic        lose = 1'b0;
  logic [2:0]  active_frog;
  logic        move_valid;
  logic [1:0]  move_dir;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        halted;
  logic [15:0] issued_count;

  int checks = 0;
  int errors = 0;
  int rises  = 0;
  logic last_valid = 1'b0;

  frog_move_scheduler #(
    .FIFO_DEPTH(DEPTH), .REPEAT_FRAMES(REP), .COOLDOWN_FRAMES(COOL)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .keycode(keycode), .frame_vs(frame_vs),
    .dead_frog(dead_frog), .win(win), .lose(lose),
    .active_frog(active_frog), .move_valid(move_valid), .move_dir(move_dir),
    .fifo_count(fifo_count), .overflow(overflow), .halted(halted),
    .issued_count(issued_count)
  );

  always #10 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_arrow(input logic [7:0] k);
    return (k >= 8'h4F) && (k <= 8'h52);
  endfunction

  function automatic int m_dir_of(input logic [7:0] k);
    return 32'h52 - int'(k);
  endfunction

  function automatic logic [2:0] m_sel(input logic [7:0] k);
    if (k == 8'h59) return 3'b001;
    if (k == 8'h5A) return 3'b010;
    if (k == 8'h5B) return 3'b100;
    return 3'b000;
  endfunction

  // reference model state
  int         q[$];
  logic [3:0] hist = 4'b0;
  logic [7:0] m_prev = 8'h00;
  logic [2:0] m_frog = 3'b000;
  bit         m_ovf = 1'b0;
  int         m_phase = PH_IDLE;
  int         m_rest = 0;
  int         m_rep = 0;
  int         m_dir = 0;
  int         m_issued = 0;

  always @(posedge Clk) begin : model
    logic [7:0] k;
    bit tick, sel, arr_press, held, rep_push, push, hin;
    int exp_issued;
    k = keycode[7:0];
    if (!Reset_n) begin
      q.delete();
      hist = 4'b0; m_prev = 8'h00; m_frog = 3'b000; m_ovf = 1'b0;
      m_phase = PH_IDLE; m_rest = 0; m_rep = 0; m_dir = 0; m_issued = 0;
    end else begin
      tick = hist[2] && !hist[3];
      hist = {hist[2:0], frame_vs};
      sel       = (k != m_prev) && (m_sel(k) != 3'b000);
      arr_press = (k != m_prev) && m_arrow(k);
      held      = m_arrow(k) && (k == m_prev);
      rep_push  = 1'b0;
      if (!held) m_rep = 0;
      else if (tick) begin
        if (m_rep + 1 == REP) begin rep_push = 1'b1; m_rep = 0; end
        else m_rep++;
      end
      push = (arr_press || rep_push) && (m_frog != 3'b000) && (m_phase != PH_HALT);
      hin  = dead_frog || win || lose;
      if (hin) m_phase = PH_HALT;
      else if (tick) begin
        case (m_phase)
          PH_IDLE: if (q.size() > 0 && m_frog != 3'b000 && !sel) begin
            m_dir = q.pop_front();
            m_phase = PH_MOVING;
            m_issued++;
          end
          PH_MOVING: begin m_rest = COOL; m_phase = (COOL == 0) ? PH_IDLE : PH_REST; end
          PH_REST: begin m_rest--; if (m_rest <= 0) m_phase = PH_IDLE; end
          default: m_phase = PH_IDLE;
        endcase
      end
      if (sel || hin) q.delete();
      else if (push) begin
        if (q.size() == DEPTH) m_ovf = 1'b1;
        else q.push_back(m_dir_of(k));
      end
      if (sel) m_frog = m_sel(k);
      m_prev = k;
    end
    #1;
`ifdef MOVE_STATS_EN
    exp_issued = m_issued % 65536;
`else
    exp_issued = 0;
`endif
    chk("active_frog", active_frog, m_frog);
    chk("move_valid", move_valid, m_phase == PH_MOVING);
    if (m_phase == PH_MOVING) chk("move_dir", move_dir, m_dir);
    chk("fifo_count", fifo_count, q.size());
    chk("overflow", overflow, m_ovf);
    chk("halted", halted, m_phase == PH_HALT);
    chk("issued_count", issued_count, exp_issued);
    if (move_valid && !last_valid) rises++;
    last_valid = move_valid;
  end

  task automatic key(input logic [7:0] k);
    @(negedge Clk);
    keycode = {k ^ 8'h3C, k};
    @(negedge Clk);
  endtask

  task automatic frame();
    @(negedge Clk);
    frame_vs = 1'b1;
    repeat (4) @(negedge Clk);
    frame_vs = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  initial begin : stim
    int r0;
    // no frog selected: arrow held through reset and frames never queues
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    frames(4);
    chk("s1_active_frog", active_frog, 3'b000);
    chk("s1_fifo_count", fifo_count, 0);
    chk("s1_no_valid", rises, 0);

    // select frog 1, queue up then right
    key(8'h5A);
    chk("s2_active_frog", active_frog, 3'b010);
    key(8'h52); key(8'h00); key(8'h4F);
    chk("s2_fifo_count", fifo_count, 2);
    frame();
    chk("s2_valid_up", move_valid, 1);
    chk("s2_dir_up", move_dir, 0);
    chk("s2_count_after_pop", fifo_count, 1);
    frame();
    chk("s2_valid_cleared", move_valid, 0);
    frame();
    chk("s2_cooldown_gap", move_valid, 0);
    frame();
    chk("s2_valid_right", move_valid, 1);
    chk("s2_dir_right", move_dir, 3);
    key(8'h00);
    frames(4);

    // five presses with no frame tick: fifth is dropped
    key(8'h52); key(8'h00); key(8'h51); key(8'h00); key(8'h50);
    key(8'h00); key(8'h4F); key(8'h00); key(8'h52);
    chk("s3_fifo_full", fifo_count, 4);
    chk("s3_overflow", overflow, 1);
    key(8'h00);
    frames(14);
    chk("s3_drained", fifo_count, 0);
    chk("s3_overflow_sticky", overflow, 1);

    // held left arrow for 20 frames: press plus repeats at tick 8 and 16
    r0 = rises;
    key(8'h50);
    frames(20);
    key(8'h00);
    frames(6);
    chk("s4_repeat_moves", rises - r0, 3);

    // dead frog mid-issue
    key(8'h52); key(8'h00); key(8'h51); key(8'h00); key(8'h50); key(8'h00);
    chk("s5_queued", fifo_count, 3);
    frame();
    chk("s5_issuing", move_valid, 1);
    @(negedge Clk); dead_frog = 1'b1;
    @(negedge Clk); dead_frog = 1'b0;
    chk("s5_valid_dropped", move_valid, 0);
    chk("s5_flushed", fifo_count, 0);
    chk("s5_halted", halted, 1);
    frame();
    chk("s5_unhalted", halted, 0);

    // selection flushes queue
    key(8'h52); key(8'h00); key(8'h51); key(8'h00); key(8'h50);
    chk("s6_queued", fifo_count, 3);
    key(8'h59);
    chk("s6_flushed", fifo_count, 0);
    chk("s6_active_frog", active_frog, 3'b001);
    key(8'h00);
    // halt and arrow press in the same cycle: flush wins
    @(negedge Clk); keycode = 16'h0052; win = 1'b1;
    @(negedge Clk); win = 1'b0; keycode = 16'h0000;
    chk("s6_halt_push_flushed", fifo_count, 0);
    chk("s6_halted_win", halted, 1);
    frame();
    @(negedge Clk); lose = 1'b1;
    frame();
    chk("s6_stay_halted", halted, 1);
    lose = 1'b0;
    frame();
    chk("s6_lose_released", halted, 0);

    // reset mid-issue
    key(8'h52); key(8'h00); key(8'h51);
    frame();
    chk("s7_issuing", move_valid, 1);
    @(negedge Clk); Reset_n = 1'b0;
    @(negedge Clk);
    chk("s7_rst_frog", active_frog, 0);
    chk("s7_rst_valid", move_valid, 0);
    chk("s7_rst_dir", move_dir, 0);
    chk("s7_rst_count", fifo_count, 0);
    chk("s7_rst_overflow", overflow, 0);
    chk("s7_rst_halted", halted, 0);
    chk("s7_rst_issued", issued_count, 0);
    Reset_n = 1'b1;
    key(8'h00);
    repeat (4) @(negedge Clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frog_move_scheduler.md
Name: frog_move_scheduler

Overview:
- Sits between the Nios keycode PIO and the three frog instances.
- Converts raw USB keycodes into frame-aligned move commands for the currently selected frog.
- Queues presses in a small FIFO and issues at most one move per frame, with optional cool-down and held-key auto-repeat.
- Halts and flushes all pending moves while a frog is dying or the game is won or lost.

Parameters:
FIFO_DEPTH, 4, move queue entries (power of 2, 2..16)
REPEAT_FRAMES, 8, frame ticks a held arrow must persist before re-push; 0 disables auto-repeat
COOLDOWN_FRAMES, 1, frame ticks of enforced gap after each issued move (0..15)

Ports:
Clk  in  1  50 MHz system clock
Reset_n  in  1  synchronous, active-low reset
keycode  in  16  raw keycode from Nios; only [7:0] decoded
frame_vs  in  1  VGA vertical sync (asynchronous to decode logic, synchronised internally)
dead_frog  in  1  any frog dying
win  in  1  game won
lose  in  1  game lost
active_frog  out  3  one-hot selected frog: bit0=0x59, bit1=0x5A, bit2=0x5B
move_valid  out  1  move command held for exactly one frame period
move_dir  out  2  0=up 0x52, 1=down 0x51, 2=left 0x50, 3=right 0x4F
fifo_count  out  $clog2(FIFO_DEPTH)+1  queued moves
overflow  out  1  sticky: a push was dropped because the FIFO was full
halted  out  1  FSM in HALT

Behaviour:
- Clocking and reset: one clock (Clk); reset is synchronous and active-low (Reset_n). All logic on posedge Clk.
- Reset values: active_frog=000, move_valid=0, move_dir=0, fifo_count=0, overflow=0, halted=0, FSM=IDLE, all counters 0.
- Frame tick:
  - frame_vs passes through a 2-FF synchroniser.
  - tick = 1-cycle pulse on the synced rising edge.
  - Latency from frame_vs rise to tick: 3 Clk cycles.
- Key decode:
  - Register prev_key = keycode[7:0] every cycle.
  - A press = keycode[7:0] != prev_key and the new value is recognised.
  - Select codes set active_frog one-hot immediately (next cycle) and flush the FIFO in the same cycle.
  - Unrecognised codes and 0x00 are ignored.
- Push conditions: an arrow press pushes move_dir only if active_frog != 0 and FSM != HALT.
- Auto-repeat:
  - While the same arrow is held, repeat_cnt increments per tick.
  - When repeat_cnt reaches REPEAT_FRAMES, push again and clear repeat_cnt.
  - Any key change clears repeat_cnt.
- FIFO:
  - Circular buffer; push when full is dropped and sets overflow.
  - Push and pop in the same cycle: both performed, count unchanged; this applies even when full.
  - Flush zeroes the pointers and count; flush wins over a simultaneous push.
- FSM:
  - IDLE: on tick with fifo_count>0 and active_frog!=0, pop the head, drive move_dir, set move_valid=1, go to ISSUE.
  - ISSUE: hold move_valid/move_dir steady. On the next tick, clear move_valid. Then go to HOLDOFF with cd_cnt=COOLDOWN_FRAMES, or to IDLE if COOLDOWN_FRAMES=0. A move is never issued on the same tick that ends ISSUE.
  - HOLDOFF: decrement cd_cnt per tick; at 0 go to IDLE.
  - HALT:
    - Entry: from any state in the cycle after dead_frog|win|lose is seen high.
    - On entry: move_valid=0, FIFO flushed, halted=1.
    - Exit: to IDLE on a tick where all three inputs are low.
- Selection change mid-ISSUE: the current move completes unchanged; only the queue is flushed.
- Reset mid-operation returns to reset values in one cycle regardless of state.

Optional Feature:
MOVE_STATS_EN:
- Defined: adds output issued_count[15:0], incremented on each IDLE->ISSUE transition. Wraps 0xFFFF->0. Cleared by reset only.
- Undefined: port present but tied to 0, with no counter logic.

Test Plan:
- Reset_n=0 for 2 cycles, keycode=0x52, 4 ticks -> active_frog=000, no push, fifo_count=0, move_valid never 1.
- keycode 0x5A then 0x52,0x00,0x4F -> active_frog=010; fifo_count=2; next tick move_valid=1, dir=0 for one frame; after cool-down, dir=3.
- With active_frog set and FSM held in HOLDOFF (COOLDOWN_FRAMES=15), press arrows 5 times with FIFO_DEPTH=4 -> fifo_count=4, overflow=1 and stays 1 until reset.
- Hold 0x50 for 20 ticks, REPEAT_FRAMES=8 -> initial push plus pushes at ticks 8 and 16 (3 total).
- Queue 3 moves, assert dead_frog 1 cycle mid-ISSUE -> next cycle move_valid=0, fifo_count=0, halted=1; first tick with inputs low -> IDLE, halted=0.
- Select 0x59 while 2 moves are queued and a push arrives the same cycle -> fifo_count=0, active_frog=001.
